multicycle_control_fsm: RTL and testbench

Moore-style main control unit for the multicycle MIPS core. It sits directly upstream of the ALU: it sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the 3-bit ALU operation select plus every datapath mux select and write enable. Its opcode and funct inputs come from the instruction register. Its zero input comes from the datapath comparator on the ALU result.

---
 rtl/multicycle_control_fsm_if.sv | 39 +++
 rtl/multicycle_control_fsm.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle control FSM and the datapath.
// The FSM side uses modport master: it reads IR fields and the zero flag, and drives every control.
interface multicycle_control_fsm_if;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned STATE_W  = 4;

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;

  logic                pc_write;
  logic                i_or_d;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic                zero_ext;
  logic [1:0]          pc_source;
  logic [ALU_W-1:0]    alu_control;
  logic                illegal;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, funct, zero,
    output pc_write, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, zero_ext, pc_source, alu_control, illegal, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, zero_ext, pc_source, alu_control, illegal, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore main control unit for the multicycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback and decodes datapath controls from the state.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal instructions park the FSM in HALT until reset;
// without it an illegal instruction flags illegal for its DECODE cycle and is retired as a NOP.
module multicycle_control_fsm (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'd1;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd3;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd4;
  localparam logic [ALU_W-1:0] ALU_LUI = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    ALU_WB_R  = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    ALU_WB_I  = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    HALT      = 4'd12
`endif
  } state_t;

  state_t state_q;
  state_t state_n;

  logic             r_ok;
  logic [ALU_W-1:0] r_alu;
  logic [ALU_W-1:0] i_alu;
  logic             i_zext;

  logic             pc_write_c;
  logic             i_or_d_c;
  logic             mem_write_c;
  logic             ir_write_c;
  logic             reg_dst_c;
  logic             mem_to_reg_c;
  logic             reg_write_c;
  logic             alu_src_a_c;
  logic [1:0]       alu_src_b_c;
  logic             zero_ext_c;
  logic [1:0]       pc_source_c;
  logic [ALU_W-1:0] alu_control_c;
  logic             illegal_c;

  // State register; synchronous reset restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_n;
    end
  end

  // R-type funct decode: ALU op and legality
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (bus.funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLL:  r_alu = ALU_SLL;
      default: r_ok  = 1'b0;
    endcase
  end

  // I-type opcode decode: ALU op and immediate extension
  always_comb begin
    i_alu  = ALU_ADD;
    i_zext = 1'b0;
    case (bus.opcode)
      OP_ANDI: begin i_alu = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_alu = ALU_OR;  i_zext = 1'b1; end
      OP_LUI:  i_alu = ALU_LUI;
      default: i_alu = ALU_ADD;
    endcase
  end

  // Next-state and control decode; reset masks every output to zero
  always_comb begin
    state_n       = FETCH;
    pc_write_c    = 1'b0;
    i_or_d_c      = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    reg_write_c   = 1'b0;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'd0;
    zero_ext_c    = 1'b0;
    pc_source_c   = 2'd0;
    alu_control_c = ALU_ADD;
    illegal_c     = 1'b0;

    case (state_q)
      FETCH: begin
        ir_write_c  = 1'b1;
        pc_write_c  = 1'b1;
        alu_src_b_c = 2'd1;
        state_n     = DECODE;
      end
      DECODE: begin
        alu_src_b_c = 2'd3;
        case (bus.opcode)
          OP_LW, OP_SW:                     state_n = MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_n = BRANCH;
          OP_J:                             state_n = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_n = EXEC_I;
          OP_RTYPE: begin
            if (r_ok) begin
              state_n = EXEC_R;
            end else begin
              illegal_c = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
              state_n   = HALT;
`else
              state_n   = FETCH;
`endif
            end
          end
          default: begin
            illegal_c = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_n   = HALT;
`else
            state_n   = FETCH;
`endif
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_n     = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        i_or_d_c = 1'b1;
        state_n  = MEM_WB;
      end
      MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_n      = FETCH;
      end
      MEM_WRITE: begin
        i_or_d_c    = 1'b1;
        mem_write_c = 1'b1;
        state_n     = FETCH;
      end
      EXEC_R: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = r_alu;
        state_n       = ALU_WB_R;
      end
      ALU_WB_R: begin
        reg_write_c   = 1'b1;
        reg_dst_c     = 1'b1;
        alu_control_c = r_alu;
        state_n       = FETCH;
      end
      BRANCH: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = ALU_SUB;
        pc_source_c   = 2'd1;
        pc_write_c    = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        state_n       = FETCH;
      end
      JUMP: begin
        pc_source_c = 2'd2;
        pc_write_c  = 1'b1;
        state_n     = FETCH;
      end
      EXEC_I: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = 2'd2;
        alu_control_c = i_alu;
        zero_ext_c    = i_zext;
        state_n       = ALU_WB_I;
      end
      ALU_WB_I: begin
        reg_write_c = 1'b1;
        state_n     = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      HALT: begin
        illegal_c = 1'b1;
        state_n   = HALT;
      end
`endif
      default: state_n = FETCH;
    endcase

    if (reset) begin
      pc_write_c    = 1'b0;
      i_or_d_c      = 1'b0;
      mem_write_c   = 1'b0;
      ir_write_c    = 1'b0;
      reg_dst_c     = 1'b0;
      mem_to_reg_c  = 1'b0;
      reg_write_c   = 1'b0;
      alu_src_a_c   = 1'b0;
      alu_src_b_c   = 2'd0;
      zero_ext_c    = 1'b0;
      pc_source_c   = 2'd0;
      alu_control_c = ALU_ADD;
      illegal_c     = 1'b0;
    end
  end

  // Drive the control bus
  assign bus.pc_write    = pc_write_c;
  assign bus.i_or_d      = i_or_d_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.zero_ext    = zero_ext_c;
  assign bus.pc_source   = pc_source_c;
  assign bus.alu_control = alu_control_c;
  assign bus.illegal     = illegal_c;
  assign bus.state       = reset ? STATE_W'(0) : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: a per-instruction reference model queues the
// expected control vector of every cycle; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;
  } rec_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic clk;
  logic reset;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t  exp_q[$];
  string tag_q[$];
  rec_t  model_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic rec_t sample();
    rec_t a;
    a.pc_write    = bus.pc_write;
    a.i_or_d      = bus.i_or_d;
    a.mem_write   = bus.mem_write;
    a.ir_write    = bus.ir_write;
    a.reg_dst     = bus.reg_dst;
    a.mem_to_reg  = bus.mem_to_reg;
    a.reg_write   = bus.reg_write;
    a.alu_src_a   = bus.alu_src_a;
    a.alu_src_b   = bus.alu_src_b;
    a.zero_ext    = bus.zero_ext;
    a.pc_source   = bus.pc_source;
    a.alu_control = bus.alu_control;
    a.illegal     = bus.illegal;
    a.state       = bus.state;
    return a;
  endfunction

  // ALU op required by an R-type funct (0 add, 1 sll, 2 or, 3 and, 4 sub)
  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'd4;
      6'h24:   return 3'd3;
      6'h25:   return 3'd2;
      6'h00:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R) return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h00});
    return (op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI});
  endfunction

  // Reference model: the whole cycle-by-cycle control trace of one instruction
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z);
    rec_t r;
    model_q.delete();
    r = '0; r.state = 4'd0; r.ir_write = 1'b1; r.pc_write = 1'b1; r.alu_src_b = 2'd1;
    model_q.push_back(r);
    r = '0; r.state = 4'd1; r.alu_src_b = 2'd3; r.illegal = !is_legal(op, fn);
    model_q.push_back(r);
    if (!is_legal(op, fn)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int k = 0; k < 10; k++) begin
        r = '0; r.state = 4'd12; r.illegal = 1'b1;
        model_q.push_back(r);
      end
`endif
      return;
    end
    if (op == OP_LW || op == OP_SW) begin
      r = '0; r.state = 4'd2; r.alu_src_a = 1'b1; r.alu_src_b = 2'd2;
      model_q.push_back(r);
      if (op == OP_LW) begin
        r = '0; r.state = 4'd3; r.i_or_d = 1'b1;
        model_q.push_back(r);
        r = '0; r.state = 4'd4; r.reg_write = 1'b1; r.mem_to_reg = 1'b1;
        model_q.push_back(r);
      end else begin
        r = '0; r.state = 4'd5; r.i_or_d = 1'b1; r.mem_write = 1'b1;
        model_q.push_back(r);
      end
    end else if (op == OP_R) begin
      r = '0; r.state = 4'd6; r.alu_src_a = 1'b1; r.alu_control = r_alu(fn);
      model_q.push_back(r);
      r = '0; r.state = 4'd7; r.reg_write = 1'b1; r.reg_dst = 1'b1; r.alu_control = r_alu(fn);
      model_q.push_back(r);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      r = '0; r.state = 4'd8; r.alu_src_a = 1'b1; r.alu_control = 3'd4; r.pc_source = 2'd1;
      r.pc_write = (op == OP_BEQ) ? z : !z;
      model_q.push_back(r);
    end else if (op == OP_J) begin
      r = '0; r.state = 4'd9; r.pc_source = 2'd2; r.pc_write = 1'b1;
      model_q.push_back(r);
    end else begin
      r = '0; r.state = 4'd10; r.alu_src_a = 1'b1; r.alu_src_b = 2'd2;
      r.alu_control = (op == OP_ANDI) ? 3'd3 : (op == OP_ORI) ? 3'd2 : (op == OP_LUI) ? 3'd5 : 3'd0;
      r.zero_ext = (op == OP_ANDI || op == OP_ORI);
      model_q.push_back(r);
      r = '0; r.state = 4'd11; r.reg_write = 1'b1;
      model_q.push_back(r);
    end
  endtask

  task automatic push_exp(input rec_t r, input string tag);
    exp_q.push_back(r);
    tag_q.push_back(tag);
  endtask

  // Issue one instruction from a FETCH cycle and wait for it to retire
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z, input string name);
    int n;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    build(op, fn, z);
    n = model_q.size();
    for (int k = 0; k < n; k++) push_exp(model_q[k], $sformatf("%s op=%h fn=%h z=%0d cyc%0d", name, op, fn, z, k));
    repeat (n) @(posedge clk);
    #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (!is_legal(op, fn)) begin
      reset = 1'b1;
      push_exp('0, "halt exit reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
`endif
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    rec_t  e;
    rec_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t, a, a.state, e, e.state);
      end
    end
  end

  logic [5:0] op_pool [10];
  logic [5:0] fn_pool [5];

  initial begin
    int   left;
    rec_t z;
    op_pool = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};
    z = '0;
    reset = 1'b1;
    bus.opcode = 6'h00;
    bus.funct  = 6'h20;
    bus.zero   = 1'b0;

    @(posedge clk);
    #1;
    push_exp(z, "power-on reset 0");
    push_exp(z, "power-on reset 1");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(OP_R,    6'h22, 1'b0, "sub");
    run_instr(OP_LW,   6'h00, 1'b0, "lw");
    run_instr(OP_SW,   6'h00, 1'b0, "sw");
    run_instr(OP_BEQ,  6'h00, 1'b1, "beq taken");
    run_instr(OP_BEQ,  6'h00, 1'b0, "beq not taken");
    run_instr(OP_BNE,  6'h00, 1'b0, "bne taken");
    run_instr(OP_BNE,  6'h00, 1'b1, "bne not taken");
    run_instr(OP_J,    6'h00, 1'b0, "j");
    run_instr(OP_LUI,  6'h00, 1'b0, "lui");
    run_instr(OP_ORI,  6'h00, 1'b0, "ori");
    run_instr(OP_ANDI, 6'h00, 1'b0, "andi");
    run_instr(OP_ADDI, 6'h00, 1'b0, "addi");
    run_instr(OP_R,    6'h00, 1'b0, "sll");
    run_instr(OP_3F_const(), 6'h00, 1'b0, "illegal op");
    run_instr(OP_R,    6'h3F, 1'b0, "illegal funct");

    // Reset held three cycles while a lw sits in MEM_READ
    bus.opcode = OP_LW;
    bus.funct  = 6'h00;
    build(OP_LW, 6'h00, 1'b0);
    for (int k = 0; k < 3; k++) push_exp(model_q[k], $sformatf("lw before reset cyc%0d", k));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(z, $sformatf("mid-lw reset cyc%0d", k));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(OP_R, 6'h25, 1'b0, "or after reset");

    for (int i = 0; i < 80; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int         sel;
      sel = $urandom_range(0, 11);
      if (sel >= 10) op = 6'($urandom_range(0, 63));
      else           op = op_pool[sel];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
      else                           fn = fn_pool[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), "rand");
    end

    left = 50;
    while (exp_q.size() > 0 && left > 0) begin
      @(posedge clk);
      left--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [5:0] OP_3F_const();
    return 6'h3F;
  endfunction

endmodule
